mem_access: RTL and testbench



---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access_load_extend.sv | 29 ++
 rtl/mem_access.sv | 136 +++++++++++++
 tb/tb_mem_access.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared opcodes, operation codes, FSM encoding and helpers for
//            the MEM-stage access block.
// Revision : 1.0  initial release
// ============================================================================
package mem_access_pkg;

    localparam int OPT_W      = 4;
    localparam int REG_ADDR_W = 5;

    typedef logic [OPT_W-1:0]      opt_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    localparam opt_t c_OPT_NOP = 4'd0;
    localparam opt_t c_OPT_LB  = 4'd1;
    localparam opt_t c_OPT_LH  = 4'd2;
    localparam opt_t c_OPT_LW  = 4'd3;
    localparam opt_t c_OPT_LBU = 4'd4;
    localparam opt_t c_OPT_LHU = 4'd5;
    localparam opt_t c_OPT_SB  = 4'd6;
    localparam opt_t c_OPT_SH  = 4'd7;
    localparam opt_t c_OPT_SW  = 4'd8;

    localparam reg_addr_t c_NOP_REG_ADDR = '0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Index of the final byte of an access; unknown widths fall back to one byte.
    function automatic logic [1:0] last_byte_idx(input opt_t opt);
        case (opt)
            c_OPT_LH, c_OPT_LHU, c_OPT_SH: last_byte_idx = 2'd1;
            c_OPT_LW, c_OPT_SW:            last_byte_idx = 2'd3;
            default:                       last_byte_idx = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Byte-wide request/acknowledge port between the MEM stage
//            (master) and the memory controller (slave).
// Revision : 1.0  initial release
// ============================================================================
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        dout;
    logic [7:0]        din;
    logic              ack;

    modport master (output req, wr, addr, dout, input din, ack);
    modport slave  (input req, wr, addr, dout, output din, ack);
endinterface
`default_nettype wire

// File: rtl/mem_access_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_load_extend
// Purpose  : Sign/zero extension of assembled load bytes by operation code.
// Revision : 1.0  initial release
// ============================================================================
module mem_access_load_extend
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     data,
    input  opt_t            opt,
    output logic [XLEN-1:0] ext
);

    always_comb begin
        ext = XLEN'(data);
        case (opt)
            c_OPT_LB:  ext = {{(XLEN-8){data[7]}},   data[7:0]};
            c_OPT_LH:  ext = {{(XLEN-16){data[15]}}, data[15:0]};
            c_OPT_LBU: ext = {{(XLEN-8){1'b0}},      data[7:0]};
            c_OPT_LHU: ext = {{(XLEN-16){1'b0}},     data[15:0]};
            default:   ext = XLEN'(data);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM stage. Passes ALU results to write-back and serialises
//            loads/stores into byte transfers, stalling the pipeline meanwhile.
//            Define MEM_ALIGN_CHECK_EN to reject misaligned half/word accesses.
// Revision : 1.0  initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rdy,
    input  logic [6:0]      mem_opcode,
    input  opt_t            mem_opt,
    input  logic            mem_we,
    input  reg_addr_t       mem_waddr,
    input  logic [XLEN-1:0] mem_alu,
    input  logic [XLEN-1:0] mem_rdata2,
    output logic            wb_we,
    output reg_addr_t       wb_waddr,
    output logic [XLEN-1:0] wb_wdata,
    output logic            stallreq_mem,
    output logic            misalign_err,
    mem_access_if.master    mc
);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [1:0]      r_idx;
    logic [31:0]     r_data;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_mem;
    logic            w_misaligned;
    logic [1:0]      w_last_idx;
    logic [XLEN-1:0] w_ext;

    assign w_is_load  = (mem_opcode == c_OP_LOAD);
    assign w_is_store = (mem_opcode == c_OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_last_idx = last_byte_idx(mem_opt);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_is_mem &&
                          (((w_last_idx == 2'd1) && mem_alu[0]) ||
                           ((w_last_idx == 2'd3) && (mem_alu[1:0] != 2'b00)));
    assign misalign_err = rst_n && (r_state == c_ST_DONE) && w_misaligned;
`else
    assign w_misaligned = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_is_mem) w_state_nxt = w_misaligned ? c_ST_DONE : c_ST_BUSY;
            c_ST_BUSY: if (mc.ack && (r_idx == w_last_idx)) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // rdy low freezes everything, including any acknowledge seen that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 2'd0;
            r_data  <= 32'd0;
        end else if (rdy) begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_BUSY) begin
                if (mc.ack) begin
                    if (w_is_load) r_data[{r_idx, 3'b000} +: 8] <= mc.din;
                    r_idx <= r_idx + 2'd1;
                end
            end else begin
                r_idx <= 2'd0;
            end
        end
    end

    mem_access_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .data (r_data),
        .opt  (mem_opt),
        .ext  (w_ext)
    );

    // Outputs follow the held EX/MEM inputs; reset forces them idle at once.
    always_comb begin
        wb_we        = 1'b0;
        wb_waddr     = c_NOP_REG_ADDR;
        wb_wdata     = '0;
        stallreq_mem = 1'b0;
        mc.req       = 1'b0;
        mc.wr        = 1'b0;
        mc.addr      = '0;
        mc.dout      = 8'd0;
        if (rst_n) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_is_mem) begin
                        stallreq_mem = 1'b1;
                    end else begin
                        wb_we    = mem_we;
                        wb_waddr = mem_waddr;
                        wb_wdata = mem_alu;
                    end
                end
                c_ST_BUSY: begin
                    stallreq_mem = 1'b1;
                    mc.req       = 1'b1;
                    mc.wr        = w_is_store;
                    mc.addr      = ADDR_W'(mem_alu) + ADDR_W'(r_idx);
                    mc.dout      = mem_rdata2[{r_idx, 3'b000} +: 8];
                end
                c_ST_DONE: begin
                    if (w_is_load && !w_misaligned) begin
                        wb_we    = mem_we;
                        wb_waddr = mem_waddr;
                        wb_wdata = w_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Self-checking bench for mem_access with a byte-bus responder
//            and transfer/write-back scoreboards.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [6:0]  mem_opcode;
    opt_t        mem_opt;
    logic        mem_we;
    reg_addr_t   mem_waddr;
    logic [31:0] mem_alu;
    logic [31:0] mem_rdata2;
    logic        wb_we;
    reg_addr_t   wb_waddr;
    logic [31:0] wb_wdata;
    logic        stallreq_mem;
    logic        misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {logic wr; logic [31:0] addr; logic [7:0] dout;} bus_t;
    typedef struct {logic we; reg_addr_t waddr; logic [31:0] wdata; logic we_only;} wb_t;
    bus_t bus_q[$];
    wb_t  wb_q[$];

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32)) mc ();

    mem_access #(.XLEN(32), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rdy          (rdy),
        .mem_opcode   (mem_opcode),
        .mem_opt      (mem_opt),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_alu      (mem_alu),
        .mem_rdata2   (mem_rdata2),
        .wb_we        (wb_we),
        .wb_waddr     (wb_waddr),
        .wb_wdata     (wb_wdata),
        .stallreq_mem (stallreq_mem),
        .misalign_err (misalign_err),
        .mc           (mc)
    );

    task automatic drive_op(input logic [6:0] opc, input opt_t opt, input logic we,
                            input reg_addr_t wa, input logic [31:0] alu, input logic [31:0] d2);
        mem_opcode = opc; mem_opt = opt; mem_we = we;
        mem_waddr = wa; mem_alu = alu; mem_rdata2 = d2;
    endtask

    // One load/store from presentation to write-back, acting as the memory controller.
    task automatic do_access(input string name, input logic [6:0] opc, input opt_t opt,
                             input logic we, input reg_addr_t wa, input logic [31:0] alu,
                             input logic [31:0] d2, input logic [31:0] rd_word, input int n_bytes,
                             input int rdy_gap, input int ack_wait, input logic [31:0] exp_data);
        logic store, mis, done;
        int   n, b, k, rgap, await, exp_k;
        bus_t e;
        wb_t  w;
        store = (opc == c_OP_STORE);
        n = n_bytes; mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        if ((n == 2 && alu[0]) || (n == 4 && alu[1:0] != 2'b00)) begin mis = 1'b1; n = 0; end
`endif
        for (int i = 0; i < n; i++) bus_q.push_back('{store, alu + 32'(i), d2[8*i +: 8]});
        wb_q.push_back('{we && !store && !mis, wa, exp_data, store || mis});
        exp_k = n + 1 + ((n > 1) ? (rdy_gap + ack_wait) : 0);

        @(posedge clk); #1;
        drive_op(opc, opt, we, wa, alu, d2);
        mc.ack = 1'b0; rdy = 1'b1;
        @(negedge clk);
        n_checks++; if (stallreq_mem !== 1'b1) begin n_fail++; $display("FAIL %s idle_stall got %b want 1", name, stallreq_mem); end
        n_checks++; if (mc.req !== 1'b0 || wb_we !== 1'b0) begin n_fail++; $display("FAIL %s idle_req_we got %b/%b want 0/0", name, mc.req, wb_we); end
        n_checks++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL %s idle_misalign got %b want 0", name, misalign_err); end

        b = 0; rgap = 0; await = 0; done = 1'b0;
        for (k = 1; k <= 40 && !done; k++) begin
            @(posedge clk); #1;
            mc.ack = 1'b0; rdy = 1'b1; mc.din = 8'hEE;
            if (mc.req) begin
                if (bus_q.size() == 0) begin
                    n_checks++; n_fail++; $display("FAIL %s extra_req got addr %h want no request", name, mc.addr);
                end else begin
                    e = bus_q[0];
                    n_checks++; if (mc.addr !== e.addr) begin n_fail++; $display("FAIL %s addr got %h want %h", name, mc.addr, e.addr); end
                    n_checks++; if (mc.wr !== e.wr) begin n_fail++; $display("FAIL %s wr got %b want %b", name, mc.wr, e.wr); end
                    if (e.wr) begin
                        n_checks++; if (mc.dout !== e.dout) begin n_fail++; $display("FAIL %s dout got %h want %h", name, mc.dout, e.dout); end
                    end
                    n_checks++; if (stallreq_mem !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL %s busy_stall_we got %b/%b want 1/0", name, stallreq_mem, wb_we); end
                    if (b == 1 && rgap < rdy_gap) begin
                        rdy = 1'b0; mc.ack = 1'b1; rgap++;
                    end else if (b == 1 && await < ack_wait) begin
                        await++;
                    end else begin
                        mc.ack = 1'b1; mc.din = rd_word[8*b +: 8];
                        void'(bus_q.pop_front()); b++;
                    end
                end
            end else if (!stallreq_mem) begin
                done = 1'b1;
                w = wb_q.pop_front();
                n_checks++; if (k !== exp_k) begin n_fail++; $display("FAIL %s latency got %0d want %0d", name, k, exp_k); end
                n_checks++; if (wb_we !== w.we) begin n_fail++; $display("FAIL %s wb_we got %b want %b", name, wb_we, w.we); end
                if (!w.we_only) begin
                    n_checks++; if (wb_wdata !== w.wdata) begin n_fail++; $display("FAIL %s wb_wdata got %h want %h", name, wb_wdata, w.wdata); end
                    n_checks++; if (wb_waddr !== w.waddr) begin n_fail++; $display("FAIL %s wb_waddr got %0d want %0d", name, wb_waddr, w.waddr); end
                end
                n_checks++; if (misalign_err !== mis) begin n_fail++; $display("FAIL %s misalign got %b want %b", name, misalign_err, mis); end
                n_checks++; if (bus_q.size() != 0) begin n_fail++; $display("FAIL %s pending_bytes got %0d want 0", name, bus_q.size()); bus_q.delete(); end
            end else begin
                n_checks++; n_fail++; $display("FAIL %s stall_without_req got req=0 stall=1 want req or done", name);
            end
        end
        if (!done) begin
            n_checks++; n_fail++; $display("FAIL %s timeout got no write-back want done within 40 cycles", name);
            bus_q.delete(); wb_q.delete();
        end
        mc.ack = 1'b0; rdy = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++; if (mc.req !== 1'b0 || mc.wr !== 1'b0) begin n_fail++; $display("FAIL %s req_wr got %b/%b want 0/0", name, mc.req, mc.wr); end
        n_checks++; if (mc.addr !== 32'd0 || mc.dout !== 8'd0) begin n_fail++; $display("FAIL %s addr_dout got %h/%h want 0/0", name, mc.addr, mc.dout); end
        n_checks++; if (stallreq_mem !== 1'b0 || misalign_err !== 1'b0) begin n_fail++; $display("FAIL %s stall_mis got %b/%b want 0/0", name, stallreq_mem, misalign_err); end
        n_checks++; if (wb_we !== 1'b0 || wb_waddr !== c_NOP_REG_ADDR || wb_wdata !== 32'd0) begin n_fail++; $display("FAIL %s wb got %b/%0d/%h want 0/0/0", name, wb_we, wb_waddr, wb_wdata); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rdy = 1'b1; mc.ack = 1'b0; mc.din = 8'h00;
        drive_op(c_OP_LOAD, c_OPT_LW, 1'b1, 5'd9, 32'h100, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        drive_op(7'd0, c_OPT_NOP, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        logic [31:0] alus [2] = '{32'h0000_1234, 32'hDEAD_BEEF};
        reg_addr_t   was  [2] = '{5'd5, 5'd31};
        logic        wes  [2] = '{1'b1, 1'b0};
        wb_t w;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive_op(OP_ADD, c_OPT_NOP, wes[i], was[i], alus[i], 32'h5555_5555);
            wb_q.push_back('{wes[i], was[i], alus[i], 1'b0});
            #1;
            w = wb_q.pop_front();
            n_checks++; if (wb_we !== w.we || wb_waddr !== w.waddr || wb_wdata !== w.wdata) begin n_fail++; $display("FAIL pass%0d wb got %b/%0d/%h want %b/%0d/%h", i, wb_we, wb_waddr, wb_wdata, w.we, w.waddr, w.wdata); end
            n_checks++; if (stallreq_mem !== 1'b0 || mc.req !== 1'b0) begin n_fail++; $display("FAIL pass%0d stall_req got %b/%b want 0/0", i, stallreq_mem, mc.req); end
        end
    endtask

    task automatic test_loads();
        do_access("lw",    c_OP_LOAD, c_OPT_LW,  1'b1, 5'd7,  32'h100, 32'h0, 32'h1234_5678, 4, 0, 0, 32'h1234_5678);
        do_access("lb",    c_OP_LOAD, c_OPT_LB,  1'b1, 5'd8,  32'h20,  32'h0, 32'h0000_0080, 1, 0, 0, 32'hFFFF_FF80);
        do_access("lbu",   c_OP_LOAD, c_OPT_LBU, 1'b1, 5'd9,  32'h20,  32'h0, 32'h0000_0080, 1, 0, 0, 32'h0000_0080);
        do_access("lh",    c_OP_LOAD, c_OPT_LH,  1'b1, 5'd10, 32'h24,  32'h0, 32'h0000_9000, 2, 0, 0, 32'hFFFF_9000);
        do_access("lhu",   c_OP_LOAD, c_OPT_LHU, 1'b1, 5'd11, 32'h24,  32'h0, 32'h0000_9000, 2, 0, 0, 32'h0000_9000);
        do_access("lw_we0", c_OP_LOAD, c_OPT_LW, 1'b0, 5'd12, 32'h200, 32'h0, 32'hA5A5_0F0F, 4, 0, 0, 32'hA5A5_0F0F);
    endtask

    task automatic test_stores();
        do_access("sh_odd", c_OP_STORE, c_OPT_SH, 1'b1, 5'd3, 32'h31, 32'hAABB_CCDD, 32'h0, 2, 0, 0, 32'h0);
        do_access("sb",     c_OP_STORE, c_OPT_SB, 1'b1, 5'd4, 32'h07, 32'h1122_335A, 32'h0, 1, 0, 0, 32'h0);
        do_access("sw",     c_OP_STORE, c_OPT_SW, 1'b0, 5'd0, 32'h80, 32'hCAFE_BABE, 32'h0, 4, 0, 0, 32'h0);
    endtask

    task automatic test_addr_wrap();
        do_access("lw_wrap", c_OP_LOAD, c_OPT_LW, 1'b1, 5'd13, 32'hFFFF_FFFE, 32'h0, 32'hCAFE_F00D, 4, 0, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_stall_rdy();
        do_access("lw_slow", c_OP_LOAD, c_OPT_LW, 1'b1, 5'd14, 32'h100, 32'h0, 32'h1234_5678, 4, 2, 3, 32'h1234_5678);
    endtask

    task automatic test_back_to_back();
        wb_t w;
        do_access("b2b_lbu", c_OP_LOAD,  c_OPT_LBU, 1'b1, 5'd15, 32'h40, 32'h0, 32'h0000_00FE, 1, 0, 0, 32'h0000_00FE);
        do_access("b2b_sh",  c_OP_STORE, c_OPT_SH,  1'b0, 5'd0,  32'h42, 32'h0000_BEEF, 32'h0, 2, 0, 0, 32'h0);
        do_access("b2b_lh",  c_OP_LOAD,  c_OPT_LH,  1'b1, 5'd16, 32'h44, 32'h0, 32'h0000_7FFF, 2, 0, 0, 32'h0000_7FFF);
        @(posedge clk); #1;
        drive_op(OP_ADD, c_OPT_NOP, 1'b1, 5'd17, 32'h0BAD_F00D, 32'h0);
        wb_q.push_back('{1'b1, 5'd17, 32'h0BAD_F00D, 1'b0});
        #1;
        w = wb_q.pop_front();
        n_checks++; if (wb_we !== w.we || wb_waddr !== w.waddr || wb_wdata !== w.wdata) begin n_fail++; $display("FAIL b2b_add wb got %b/%0d/%h want %b/%0d/%h", wb_we, wb_waddr, wb_wdata, w.we, w.waddr, w.wdata); end
    endtask

    task automatic test_reset_mid_access();
        int got;
        @(posedge clk); #1;
        drive_op(c_OP_STORE, c_OPT_SW, 1'b0, 5'd0, 32'h40, 32'h1122_3344);
        mc.ack = 1'b0; rdy = 1'b1; got = 0;
        for (int k = 0; k < 10 && got < 2; k++) begin
            @(posedge clk); #1;
            mc.ack = mc.req;
            if (mc.req) got++;
        end
        @(posedge clk); #1;
        mc.ack = 1'b0;
        n_checks++; if (mc.req !== 1'b1 || mc.addr !== 32'h42) begin n_fail++; $display("FAIL rst_mid byte2 got req=%b addr=%h want 1/00000042", mc.req, mc.addr); end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid_now");
        @(posedge clk); #1;
        check_reset_outputs("rst_mid_next");
        drive_op(OP_ADD, c_OPT_NOP, 1'b1, 5'd21, 32'h0000_4242, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd21 || wb_wdata !== 32'h4242) begin n_fail++; $display("FAIL rst_mid idle_pass got %b/%0d/%h want 1/21/00004242", wb_we, wb_waddr, wb_wdata); end
        n_checks++; if (mc.req !== 1'b0 || stallreq_mem !== 1'b0) begin n_fail++; $display("FAIL rst_mid idle_req got %b/%b want 0/0", mc.req, stallreq_mem); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_addr_wrap();
        test_stall_rdy();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
